ddr_rw_arbiter: RTL and testbench
=================================

Name: ddr_rw_arbiter

Overview:
- Shares the single MIG user-interface command port between one write master and one read master.
- The write master is the burst write controller; the read master uses the same req/ack/done handshake.
- Grants one master at a time, round-robin on contention, and muxes app_cmd/app_en/app_addr/app_rdy to the owner.
- Sits between the two DDR controllers and the MIG app interface.

Parameters:
ADDR_W, 29, MIG app_addr width
WDOG_CYCLES, 4096, grant timeout in ui_clk cycles (used only with ARB_WDOG_EN)

Ports:
ui_clk  in  1  clock
rst  in  1  reset, synchronous, active-high
init_calib_complete  in  1  MIG calibration done
wr_req  in  1  write master request (level)
wr_ack  out  1  write grant pulse
wr_done  in  1  write master burst complete pulse
wr_app_cmd  in  3  write master command
wr_app_en  in  1  write master command enable
wr_app_addr  in  ADDR_W  write master address
wr_app_rdy  out  1  app_rdy routed to write master
rd_req  in  1  read master request (level)
rd_ack  out  1  read grant pulse
rd_done  in  1  read master burst complete pulse
rd_app_cmd  in  3  read master command
rd_app_en  in  1  read master command enable
rd_app_addr  in  ADDR_W  read master address
rd_app_rdy  out  1  app_rdy routed to read master
app_rdy  in  1  MIG command ready
app_cmd  out  3  MIG command
app_en  out  1  MIG command enable
app_addr  out  ADDR_W  MIG address
grant  out  2  one-hot owner: bit0 = write, bit1 = read
arb_err  out  1  watchdog abort pulse (0 when ARB_WDOG_EN is undefined)

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE.
  - wr_ack = 0, rd_ack = 0, grant = 0, arb_err = 0.
  - last_grant = READ, so write wins the first tie.
- States:
  - IDLE: go to ARB when init_calib_complete = 1.
  - ARB:
    - If init_calib_complete = 0, go to IDLE; no grant.
    - If only wr_req is high, grant write.
    - If only rd_req is high, grant read.
    - If both are high, grant the master not in last_grant.
    - A grant registers the ack pulse and moves the state to WRITE or READ on the same edge; last_grant is updated.
  - WRITE: stays until wr_done = 1, then goes to ARB.
  - READ: stays until rd_done = 1, then goes to ARB.
- Ack timing:
  - wr_ack/rd_ack is high for exactly one cycle: the first cycle of WRITE/READ.
  - The master samples the ack at the end of that cycle and begins issuing commands.
  - The mux already selects that master during the ack cycle.
- Muxing (combinational on registered state):
  - WRITE: app_cmd/app_en/app_addr come from wr_*; wr_app_rdy = app_rdy; rd_app_rdy = 0.
  - READ: app_cmd/app_en/app_addr come from rd_*; rd_app_rdy = app_rdy; wr_app_rdy = 0.
  - IDLE/ARB: app_en = 0, app_cmd = 3'b000, app_addr = 0; both *_app_rdy = 0.
- grant mirrors the state: 2'b01 in WRITE, 2'b10 in READ, 2'b00 otherwise.
- done in the same cycle as the ack is legal: the state returns to ARB on the next edge.
- done from the non-owner is ignored.
- Req still high in the ARB cycle after done counts as a new request. Round-robin therefore alternates when both masters are continuously requesting.
- Minimum one ARB cycle between bursts; no back-to-back grant on the done edge.
- Calibration loss during WRITE/READ is ignored until done; it is checked only in IDLE/ARB.
- Reset mid-burst: immediate IDLE; app_en drops on the next cycle; masters are reset by the same rst.

Optional Feature:
- Macro ARB_WDOG_EN.
- Defined:
  - A counter clears on each grant and increments every cycle in WRITE/READ.
  - On reaching WDOG_CYCLES-1 without the owner's done: force ARB, pulse arb_err for 1 cycle, leave last_grant at the aborted master.
- Undefined: no counter; arb_err is tied to 0; a burst may hold the port indefinitely.

Test Plan:
- init_calib_complete = 0 with wr_req = 1 for 100 cycles -> wr_ack never asserts, grant = 0. Raise calib -> wr_ack pulses once, 2 cycles later.
- wr_req only; writer issues 64 commands with app_rdy = 1, then wr_done -> exactly 64 app_en cycles forwarded, addresses match wr_app_addr, rd_app_rdy = 0 throughout, grant returns to 0 the cycle after done.
- wr_req and rd_req held high, each master doing 4 bursts -> grant order W,R,W,R,W,R,W,R; each ack is a single-cycle pulse.
- rd_done pulsed while write owns the port -> ignored, state stays WRITE, no rd_ack.
- rst asserted mid-READ burst -> next cycle app_en = 0, grant = 0, acks = 0. After release with both reqs high -> write granted first.
- ARB_WDOG_EN defined with WDOG_CYCLES = 16, writer never sends wr_done -> arb_err pulses on cycle 16 after the grant, pending rd_req is granted next.

Source files
------------

// File: rtl/ddr_rw_arbiter_if.sv
// ddr_rw_arbiter_if
//   Bundles every non-clock, non-reset signal of ddr_rw_arbiter: the two
//   controller-side req/ack/done handshakes with their app command buses, and
//   the shared MIG app command port.
//
//   Modports:
//     slave  - the arbiter itself (consumes requests, drives grants and the MIG port)
//     master - the surrounding environment (write/read controllers, MIG, calib status)
//
//   Signals:
//     init_calib_complete      MIG calibration done
//     wr_req/rd_req            level requests from the write/read master
//     wr_ack/rd_ack            single-cycle grant pulses
//     wr_done/rd_done          burst-complete pulses
//     wr_app_*/rd_app_*        per-master command, enable and address
//     wr_app_rdy/rd_app_rdy    app_rdy routed back to the owning master
//     app_rdy/app_cmd/app_en/app_addr   shared MIG command port
//     grant                    one-hot owner (bit0 write, bit1 read)
//     arb_err                  watchdog abort pulse
interface ddr_rw_arbiter_if #(
   parameter int unsigned ADDR_W = 29
);
   logic              init_calib_complete;
   logic              wr_req;
   logic              wr_ack;
   logic              wr_done;
   logic [2:0]        wr_app_cmd;
   logic              wr_app_en;
   logic [ADDR_W-1:0] wr_app_addr;
   logic              wr_app_rdy;
   logic              rd_req;
   logic              rd_ack;
   logic              rd_done;
   logic [2:0]        rd_app_cmd;
   logic              rd_app_en;
   logic [ADDR_W-1:0] rd_app_addr;
   logic              rd_app_rdy;
   logic              app_rdy;
   logic [2:0]        app_cmd;
   logic              app_en;
   logic [ADDR_W-1:0] app_addr;
   logic [1:0]        grant;
   logic              arb_err;

   modport slave (
      input  init_calib_complete,
      input  wr_req, wr_done, wr_app_cmd, wr_app_en, wr_app_addr,
      input  rd_req, rd_done, rd_app_cmd, rd_app_en, rd_app_addr,
      input  app_rdy,
      output wr_ack, wr_app_rdy, rd_ack, rd_app_rdy,
      output app_cmd, app_en, app_addr, grant, arb_err
   );

   modport master (
      output init_calib_complete,
      output wr_req, wr_done, wr_app_cmd, wr_app_en, wr_app_addr,
      output rd_req, rd_done, rd_app_cmd, rd_app_en, rd_app_addr,
      output app_rdy,
      input  wr_ack, wr_app_rdy, rd_ack, rd_app_rdy,
      input  app_cmd, app_en, app_addr, grant, arb_err
   );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter
//   Shares the single MIG app command port between a burst write master and a
//   read master. One owner at a time, round-robin on contention, with a
//   mandatory ARB cycle between bursts. The owner's app_cmd/app_en/app_addr
//   are forwarded to the MIG and app_rdy is routed back only to the owner.
//
//   Ports:
//     ui_clk  - MIG user-interface clock
//     rst     - synchronous, active-high reset
//     bus     - ddr_rw_arbiter_if.slave (handshakes, command buses, grant, arb_err)
//
//   Parameters:
//     ADDR_W      - MIG app_addr width
//     WDOG_CYCLES - grant timeout in ui_clk cycles (only with ARB_WDOG_EN)
//
//   Build option:
//     `define ARB_WDOG_EN enables the grant watchdog; an owner that holds the
//     port for WDOG_CYCLES cycles without done is aborted and arb_err pulses.
//     Without it arb_err is tied low and a burst may hold the port forever.
module ddr_rw_arbiter #(
   parameter int unsigned ADDR_W      = 29,
   parameter int unsigned WDOG_CYCLES = 4096
) (
   input  logic            ui_clk,
   input  logic            rst,
   ddr_rw_arbiter_if.slave bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StArb   = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StRead  = 2'd3;

   logic [1:0] r_state;
   logic [1:0] w_state_d;
   logic       r_last_rd;     // 1: read was granted last, so write wins a tie
   logic       w_last_rd_d;
   logic       r_wr_ack;
   logic       w_wr_ack_d;
   logic       r_rd_ack;
   logic       w_rd_ack_d;
   logic       r_arb_err;
   logic       w_arb_err_d;
   logic       w_wdog_hit;

`ifdef ARB_WDOG_EN
   localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

   logic [WdogW-1:0] r_wdog_cnt;

   // Zero in IDLE/ARB, so it reads zero in the ack cycle of every grant.
   always_ff @(posedge ui_clk) begin
      if (rst) begin
         r_wdog_cnt <= '0;
      end else if (r_state == StWrite || r_state == StRead) begin
         r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end else begin
         r_wdog_cnt <= '0;
      end
   end

   assign w_wdog_hit = (r_wdog_cnt == WdogLast);
`else
   logic w_unused_wdog;
   assign w_unused_wdog = ^WDOG_CYCLES;
   assign w_wdog_hit    = 1'b0;
`endif

   always_comb begin
      w_state_d   = r_state;
      w_last_rd_d = r_last_rd;
      w_wr_ack_d  = 1'b0;
      w_rd_ack_d  = 1'b0;
      w_arb_err_d = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.init_calib_complete) w_state_d = StArb;
         end
         StArb: begin
            if (!bus.init_calib_complete) begin
               w_state_d = StIdle;
            end else if (bus.wr_req && (!bus.rd_req || r_last_rd)) begin
               w_state_d   = StWrite;
               w_wr_ack_d  = 1'b1;
               w_last_rd_d = 1'b0;
            end else if (bus.rd_req) begin
               w_state_d   = StRead;
               w_rd_ack_d  = 1'b1;
               w_last_rd_d = 1'b1;
            end
         end
         StWrite: begin
            // Calibration loss and rd_done are deliberately ignored here.
            if (bus.wr_done) begin
               w_state_d = StArb;
            end else if (w_wdog_hit) begin
               w_state_d   = StArb;
               w_arb_err_d = 1'b1;
            end
         end
         StRead: begin
            if (bus.rd_done) begin
               w_state_d = StArb;
            end else if (w_wdog_hit) begin
               w_state_d   = StArb;
               w_arb_err_d = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge ui_clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_last_rd <= 1'b1;
         r_wr_ack  <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_arb_err <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_last_rd <= w_last_rd_d;
         r_wr_ack  <= w_wr_ack_d;
         r_rd_ack  <= w_rd_ack_d;
         r_arb_err <= w_arb_err_d;
      end
   end

   assign bus.wr_ack  = r_wr_ack;
   assign bus.rd_ack  = r_rd_ack;
   assign bus.arb_err = r_arb_err;

   // Mux follows the registered owner, so it already selects the master
   // during its ack cycle.
   always_comb begin
      bus.app_cmd    = 3'b000;
      bus.app_en     = 1'b0;
      bus.app_addr   = {ADDR_W{1'b0}};
      bus.wr_app_rdy = 1'b0;
      bus.rd_app_rdy = 1'b0;
      bus.grant      = 2'b00;
      unique case (r_state)
         StWrite: begin
            bus.app_cmd    = bus.wr_app_cmd;
            bus.app_en     = bus.wr_app_en;
            bus.app_addr   = bus.wr_app_addr;
            bus.wr_app_rdy = bus.app_rdy;
            bus.grant      = 2'b01;
         end
         StRead: begin
            bus.app_cmd    = bus.rd_app_cmd;
            bus.app_en     = bus.rd_app_en;
            bus.app_addr   = bus.rd_app_addr;
            bus.rd_app_rdy = bus.app_rdy;
            bus.grant      = 2'b10;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter
//   Directed bench for ddr_rw_arbiter: a table of single-cycle vectors walks
//   the FSM through grants, round-robin, ignored done, reset and calibration
//   corners; hand-written sequences cover the long calibration hold, a
//   64-command write burst, continuous round-robin and the watchdog.
module tb_ddr_rw_arbiter;

   localparam int unsigned AW = 29;
   localparam logic [AW-1:0] WR_ADDR = 29'h00ABCDE0;
   localparam logic [AW-1:0] RD_ADDR = 29'h01234560;
   localparam logic [2:0]    WR_CMD  = 3'b000;
   localparam logic [2:0]    RD_CMD  = 3'b001;

   logic ui_clk = 1'b0;
   logic rst    = 1'b1;

   always #5 ui_clk = ~ui_clk;

   ddr_rw_arbiter_if #(.ADDR_W(AW)) bus ();

   ddr_rw_arbiter #(
      .ADDR_W      (AW),
      .WDOG_CYCLES (16)
   ) dut (
      .ui_clk (ui_clk),
      .rst    (rst),
      .bus    (bus)
   );

   // in = {rst, calib, wr_req, rd_req, wr_done, rd_done, app_rdy}
   // ex = {grant[1:0], wr_ack, rd_ack, wr_app_rdy, rd_app_rdy, arb_err}
   typedef struct packed {
      logic [6:0] in;
      logic [6:0] ex;
   } vec_t;

   vec_t vq[$];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic tick();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [6:0] in, input logic [6:0] ex);
      vq.push_back('{in: in, ex: ex});
   endtask

   task automatic clear_inputs();
      bus.init_calib_complete = 1'b0;
      bus.wr_req = 1'b0; bus.wr_done = 1'b0; bus.wr_app_en = 1'b0;
      bus.rd_req = 1'b0; bus.rd_done = 1'b0; bus.rd_app_en = 1'b0;
      bus.wr_app_cmd = WR_CMD; bus.wr_app_addr = WR_ADDR;
      bus.rd_app_cmd = RD_CMD; bus.rd_app_addr = RD_ADDR;
      bus.app_rdy = 1'b1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_ack();
      for (int k = 0; k < 10; k++) begin
         if (bus.wr_ack || bus.rd_ack) break;
         tick();
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [1:0]      eg;
      logic [63:0]     act;
      logic [63:0]     exp;
      logic [AW-1:0]   ea;
      logic [2:0]      ec;
      logic [AW-1:0]   a;
      int              en_cnt;
      int              addr_bad;
      int              rrdy_seen;
      int              bad_seen;
      int              n;
      logic [1:0]      who;
      logic [1:0]      want;

      clear_inputs();

      // ---------------- table-driven vectors ----------------
      add(7'b1000001, 7'b0000000); // reset -> IDLE
      add(7'b0010001, 7'b0000000); // no calib: stay IDLE
      add(7'b0110001, 7'b0000000); // calib -> ARB
      add(7'b0111001, 7'b0110100); // tie, last=read -> write ack
      add(7'b0111011, 7'b0100100); // rd_done from non-owner ignored
      add(7'b0111101, 7'b0000000); // wr_done -> ARB
      add(7'b0111001, 7'b1001010); // tie -> read
      add(7'b0111011, 7'b0000000); // rd_done -> ARB
      add(7'b0111001, 7'b0110100); // tie -> write
      add(7'b0111101, 7'b0000000); // done in ack cycle -> ARB
      add(7'b0101001, 7'b1001010); // read only -> read
      add(7'b1101001, 7'b0000000); // reset mid-read
      add(7'b0111001, 7'b0000000); // IDLE -> ARB
      add(7'b0111001, 7'b0110100); // write wins first tie after reset
      add(7'b0011001, 7'b0100100); // calib loss ignored while owning
      add(7'b0011101, 7'b0000000); // done -> ARB
      add(7'b0011001, 7'b0000000); // ARB without calib -> IDLE
      add(7'b0111000, 7'b0000000); // calib -> ARB
      add(7'b0111000, 7'b1001000); // tie -> read, app_rdy low routed
      add(7'b0111010, 7'b0000000); // rd_done -> ARB

      bus.wr_app_en = 1'b1;
      bus.rd_app_en = 1'b1;
      foreach (vq[i]) begin
         {rst, bus.init_calib_complete, bus.wr_req, bus.rd_req,
          bus.wr_done, bus.rd_done, bus.app_rdy} = vq[i].in;
         tick();
         eg = vq[i].ex[6:5];
         ec = (eg == 2'b10) ? RD_CMD : WR_CMD;
         ea = (eg == 2'b01) ? WR_ADDR : (eg == 2'b10) ? RD_ADDR : '0;
         if (eg == 2'b00) ec = 3'b000;
         act = {21'd0, bus.grant, bus.wr_ack, bus.rd_ack, bus.wr_app_rdy, bus.rd_app_rdy,
                bus.arb_err, bus.app_en, bus.app_cmd, bus.app_addr};
         exp = {21'd0, vq[i].ex, (eg != 2'b00), ec, ea};
         check($sformatf("vec%0d", i), act, exp);
      end

      // ---------------- calibration hold ----------------
      do_reset();
      bus.wr_req = 1'b1;
      bad_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.wr_ack || bus.grant != 2'b00) bad_seen++;
      end
      check("calib_hold", 64'(bad_seen), 64'd0);
      bus.init_calib_complete = 1'b1;
      tick();
      check("calib_ack_early", {63'd0, bus.wr_ack}, 64'd0);
      tick();
      check("calib_ack_2cyc", {62'd0, bus.wr_ack, bus.grant[0]}, 64'd3);
      tick();
      check("calib_ack_pulse", {63'd0, bus.wr_ack}, 64'd0);

      // ---------------- 64-command write burst ----------------
      do_reset();
      bus.init_calib_complete = 1'b1;
      bus.wr_req = 1'b1;
      wait_ack();
      check("burst_ack", {63'd0, bus.wr_ack}, 64'd1);
      en_cnt = 0; addr_bad = 0; rrdy_seen = 0;
      for (int i = 0; i < 64; i++) begin
         a = 29'h01000000 + AW'(i * 8);
         bus.wr_app_en   = 1'b1;
         bus.wr_app_addr = a;
         #1;
         if (bus.app_en) en_cnt++;
         if (bus.app_addr !== a || !bus.wr_app_rdy) addr_bad++;
         if (bus.rd_app_rdy) rrdy_seen++;
         tick();
      end
      bus.wr_app_en = 1'b0;
      bus.wr_done   = 1'b1;
      bus.wr_req    = 1'b0;
      #1;
      if (bus.app_en) en_cnt++;
      if (bus.rd_app_rdy) rrdy_seen++;
      tick();
      bus.wr_done = 1'b0;
      check("burst_en_count", 64'(en_cnt), 64'd64);
      check("burst_addr", 64'(addr_bad), 64'd0);
      check("burst_rd_rdy", 64'(rrdy_seen), 64'd0);
      check("burst_grant_after", {62'd0, bus.grant}, 64'd0);

      // ---------------- continuous round-robin ----------------
      do_reset();
      bus.init_calib_complete = 1'b1;
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      for (int b = 0; b < 8; b++) begin
         wait_ack();
         who  = {bus.rd_ack, bus.wr_ack};
         want = (b % 2 == 0) ? 2'b01 : 2'b10;
         check($sformatf("rr_order%0d", b), {62'd0, who}, {62'd0, want});
         tick();
         check($sformatf("rr_pulse%0d", b), {60'd0, bus.wr_ack, bus.rd_ack, bus.grant},
               {62'd0, want});
         if (want == 2'b01) bus.wr_done = 1'b1;
         else               bus.rd_done = 1'b1;
         tick();
         bus.wr_done = 1'b0;
         bus.rd_done = 1'b0;
      end

      // ---------------- watchdog ----------------
      do_reset();
      bus.init_calib_complete = 1'b1;
      bus.wr_req = 1'b1;
      wait_ack();
      check("wdog_ack", {63'd0, bus.wr_ack}, 64'd1);
      bus.rd_req = 1'b1;
`ifdef ARB_WDOG_EN
      n = 0;
      while (!bus.arb_err && n < 40) begin
         tick();
         n++;
      end
      check("wdog_cycles", 64'(n), 64'd16);
      check("wdog_grant_drop", {62'd0, bus.grant}, 64'd0);
      tick();
      check("wdog_read_next", {61'd0, bus.rd_ack, bus.grant}, {61'd0, 1'b1, 2'b10});
      check("wdog_err_pulse", {63'd0, bus.arb_err}, 64'd0);
`else
      bad_seen = 0;
      for (n = 0; n < 40; n++) begin
         tick();
         if (bus.arb_err || bus.grant != 2'b01) bad_seen++;
      end
      check("no_wdog_hold", 64'(bad_seen), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
